// File: rtl/period_meter_if.sv
`timescale 1ns/1ps
// Measured signal in, period/high-time results out.
// master = the meter, slave = the consumer that also sources sigin.
interface period_meter_if #(
    parameter int W = 27
);
    logic         sigin;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         valid;
    logic         timeout;
    logic         locked;

    modport master (
        input  sigin,
        output period,
        output high_time,
        output valid,
        output timeout,
        output locked
    );

    modport slave (
        output sigin,
        input  period,
        input  high_time,
        input  valid,
        input  timeout,
        input  locked
    );
endinterface

// File: rtl/period_meter.sv
`timescale 1ns/1ps
// Measures period and high time of an async square wave in inclk cycles, with timeout and lock.
// Latency: 3-4 cycles from the sigin rising edge to valid; no backpressure, valid is a one-cycle pulse.
module period_meter #(
    parameter int W       = 27,
    parameter int TIMEOUT = 100_000_000,
    parameter int TOL     = 1
) (
    input  logic           inclk,
    input  logic           reset_n,
    period_meter_if.master pm
);
    localparam logic [W-1:0] CNT_MAX = W'(TIMEOUT - 1);
    localparam logic [W-1:0] TOL_W   = W'(TOL);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t       state;
    logic         s1, s2, s3;
    logic [W-1:0] cnt;
    logic [W-1:0] hpend;
    logic [W-1:0] prev;
    logic         have_prev;
    logic [W-1:0] period_q;
    logic [W-1:0] high_q;
    logic         valid_q;
    logic         timeout_q;
    logic         locked_q;

    logic         rise;
    logic         fall;
    logic         at_max;
    logic [W-1:0] cnt_inc;
    logic [W-1:0] diff;

    assign rise    = s2 & ~s3;
    assign fall    = ~s2 & s3;
    assign at_max  = (cnt == CNT_MAX);
    assign cnt_inc = cnt + W'(1);
    // Magnitude without wrap: always subtract the smaller from the larger.
    assign diff    = (cnt_inc >= prev) ? (cnt_inc - prev) : (prev - cnt_inc);

    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            cnt       <= '0;
            hpend     <= '0;
            prev      <= '0;
            have_prev <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            s1      <= pm.sigin;
            s2      <= s1;
            s3      <= s2;
            valid_q <= 1'b0;

            if (rise) begin
                cnt <= '0;
            end else if (!at_max) begin
                cnt <= cnt_inc;
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        state     <= MEASURE;
                        timeout_q <= 1'b0;
                    end
                end
                MEASURE: begin
                    // A rise landing on the saturation cycle is a legal period of exactly TIMEOUT.
                    if (rise) begin
                        period_q  <= cnt_inc;
                        high_q    <= hpend;
                        valid_q   <= 1'b1;
                        prev      <= cnt_inc;
                        have_prev <= 1'b1;
                        timeout_q <= 1'b0;
                        if (have_prev) begin
                            locked_q <= (diff <= TOL_W);
                        end
                    end else if (at_max) begin
                        state     <= IDLE;
                        timeout_q <= 1'b1;
                        locked_q  <= 1'b0;
                        have_prev <= 1'b0;
                    end else if (fall) begin
                        hpend <= cnt_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pm.period    = period_q;
    assign pm.high_time = high_q;
    assign pm.valid     = valid_q;
    assign pm.timeout   = timeout_q;
    assign pm.locked    = locked_q;
endmodule

// File: tb/tb_period_meter.sv
`timescale 1ns/1ps
// Directed bench for period_meter: divider, duty cycle, timeout, lock tolerance, TIMEOUT boundary, reset.
module tb_period_meter;
    localparam int W  = 27;
    localparam int TO = 50;

    logic inclk   = 1'b0;
    logic reset_n = 1'b0;

    period_meter_if #(.W(W)) pm ();

    period_meter #(.W(W), .TIMEOUT(TO), .TOL(1)) dut (
        .inclk   (inclk),
        .reset_n (reset_n),
        .pm      (pm)
    );

    always #5 inclk = ~inclk;

    typedef struct {
        int per;
        int ht;
        int lk;
        int c;
    } ev_t;

    ev_t evq[$];
    int  cyc     = 0;
    int  tmo_cnt = 0;
    int  total   = 0;
    int  bad     = 0;

    // Record every valid pulse with the posedge index it appeared on.
    always @(posedge inclk) begin : mon
        ev_t e;
        cyc++;
        #1;
        if (pm.valid === 1'b1) begin
            e.per = int'(pm.period);
            e.ht  = int'(pm.high_time);
            e.lk  = int'(pm.locked);
            e.c   = cyc;
            evq.push_back(e);
        end
        if (pm.timeout === 1'b1) tmo_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_ev(input string tag, input int idx, input int per, input int ht, input int lk);
        if (idx < evq.size()) begin
            chk($sformatf("%s%0d_period", tag, idx), evq[idx].per, per);
            chk($sformatf("%s%0d_high", tag, idx), evq[idx].ht, ht);
            chk($sformatf("%s%0d_locked", tag, idx), evq[idx].lk, lk);
        end else begin
            chk($sformatf("%s%0d_count", tag, idx), evq.size(), idx + 1);
        end
    endtask

    task automatic drive(input int h, input int l);
        pm.sigin = 1'b1;
        repeat (h) @(negedge inclk);
        pm.sigin = 1'b0;
        repeat (l) @(negedge inclk);
    endtask

    initial begin
        int k;
        int v;
        int t0;
        pm.sigin = 1'b0;
        reset_n  = 1'b0;
        repeat (3) @(negedge inclk);
        chk("rst_period", pm.period, 0);
        chk("rst_high", pm.high_time, 0);
        chk("rst_valid", pm.valid, 0);
        chk("rst_timeout", pm.timeout, 0);
        chk("rst_locked", pm.locked, 0);
        reset_n = 1'b1;
        @(negedge inclk);

        // Divide-by-10: first rise only arms, valids from the second rise.
        evq.delete();
        k = cyc;
        repeat (6) drive(5, 5);
        chk("div_nvalid", evq.size(), 5);
        for (int i = 0; i < 5; i++) check_ev("div", i, 10, 5, (i == 0) ? 0 : 1);
        if (evq.size() > 0) chk("div_first_at", evq[0].c, k + 13);
        for (int i = 1; i < evq.size(); i++) chk("div_gap", evq[i].c - evq[i-1].c, 10);

        // Duty 3/7: the first valid closes the last 5/5 period.
        evq.delete();
        repeat (4) drive(3, 7);
        chk("duty_nvalid", evq.size(), 4);
        check_ev("duty", 0, 10, 5, 1);
        for (int i = 1; i < 4; i++) check_ev("duty", i, 10, 3, 1);

        // Timeout after 4 periods of 10.
        evq.delete();
        repeat (4) drive(5, 5);
        chk("to_nvalid", evq.size(), 4);
        v = (evq.size() > 0) ? evq[evq.size()-1].c : cyc;
        while (cyc < v + 49) @(negedge inclk);
        chk("to_not_yet", pm.timeout, 0);
        @(negedge inclk);
        chk("to_set", pm.timeout, 1);
        chk("to_locked", pm.locked, 0);
        chk("to_period_held", pm.period, 10);
        chk("to_high_held", pm.high_time, 5);
        repeat (10) @(negedge inclk);
        chk("to_still", pm.timeout, 1);

        // Resume: timeout clears on the arming rise, lock needs two valids.
        evq.delete();
        k = cyc;
        pm.sigin = 1'b1;
        repeat (2) @(negedge inclk);
        chk("resume_to_hold", pm.timeout, 1);
        @(negedge inclk);
        chk("resume_to_clr", pm.timeout, 0);
        repeat (2) @(negedge inclk);
        pm.sigin = 1'b0;
        repeat (5) @(negedge inclk);
        repeat (3) drive(5, 5);
        chk("resume_nvalid", evq.size(), 3);
        check_ev("resume", 0, 10, 5, 0);
        check_ev("resume", 1, 10, 5, 1);
        check_ev("resume", 2, 10, 5, 1);
        if (evq.size() > 0) chk("resume_first_at", evq[0].c, k + 13);

        // Tolerance: 10 -> 20 -> 21 -> 23.
        evq.delete();
        drive(10, 10);
        drive(10, 11);
        drive(11, 12);
        pm.sigin = 1'b1;
        repeat (5) @(negedge inclk);
        pm.sigin = 1'b0;
        repeat (3) @(negedge inclk);
        chk("tol_nvalid", evq.size(), 4);
        check_ev("tol", 0, 10, 5, 1);
        check_ev("tol", 1, 20, 10, 0);
        check_ev("tol", 2, 21, 10, 1);
        check_ev("tol", 3, 23, 11, 0);

        // Period exactly TIMEOUT: rise wins over saturation.
        repeat (60) @(negedge inclk);
        chk("bnd_pre_to", pm.timeout, 1);
        evq.delete();
        k = cyc;
        pm.sigin = 1'b1;
        repeat (3) @(negedge inclk);
        chk("bnd_to_clr", pm.timeout, 0);
        t0 = tmo_cnt;
        repeat (22) @(negedge inclk);
        pm.sigin = 1'b0;
        repeat (25) @(negedge inclk);
        repeat (2) drive(25, 25);
        pm.sigin = 1'b1;
        repeat (5) @(negedge inclk);
        pm.sigin = 1'b0;
        repeat (5) @(negedge inclk);
        chk("bnd_nvalid", evq.size(), 3);
        check_ev("bnd", 0, 50, 25, 0);
        check_ev("bnd", 1, 50, 25, 1);
        check_ev("bnd", 2, 50, 25, 1);
        if (evq.size() > 1) chk("bnd_gap", evq[1].c - evq[0].c, 50);
        chk("bnd_no_timeout", tmo_cnt - t0, 0);

        // Asynchronous reset mid-period.
        repeat (3) drive(5, 5);
        chk("prerst_locked", pm.locked, 1);
        chk("prerst_period", pm.period, 10);
        pm.sigin = 1'b1;
        @(negedge inclk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_period", pm.period, 0);
        chk("arst_high", pm.high_time, 0);
        chk("arst_valid", pm.valid, 0);
        chk("arst_timeout", pm.timeout, 0);
        chk("arst_locked", pm.locked, 0);
        repeat (3) @(negedge inclk);
        reset_n = 1'b1;
        evq.delete();
        k = cyc;
        repeat (5) @(negedge inclk);
        pm.sigin = 1'b0;
        repeat (5) @(negedge inclk);
        chk("post_rst_none_a", evq.size(), 0);
        pm.sigin = 1'b1;
        repeat (2) @(negedge inclk);
        chk("post_rst_none_b", evq.size(), 0);
        repeat (3) @(negedge inclk);
        chk("post_rst_nvalid", evq.size(), 1);
        check_ev("post_rst", 0, 10, 5, 0);
        if (evq.size() > 0) chk("post_rst_at", evq[0].c, k + 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
